// File: rtl/mem_line_bridge_pkg.sv
// mem_line_bridge_pkg
//   Shared definitions for the cache-line to memory-bus bridge:
//   FSM state encoding, default widths and helpers that derive the beat
//   count and beat index width from the line and bus widths.
//   Optional feature macro used by the bridge: MEM_BRIDGE_TIMEOUT_EN.
package mem_line_bridge_pkg;

  // Default widths shared with the rest of the CPU memory path.
  localparam int ADDR_WIDTH       = 32;
  localparam int DATA_WIDTH_CACHE = 128;
  localparam int BUS_WIDTH        = 32;
  localparam int TIMEOUT_DEFAULT  = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } bridgeState_t;

  // Number of bus beats needed to move one cache line.
  function automatic int beatCount(input int lineW, input int busW);
    return lineW / busW;
  endfunction

  // Beat index width; kept at least one bit so a one-beat line still has a counter.
  function automatic int beatIdxWidth(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_line_bridge_if.sv
// mem_line_bridge_if
//   Groups the arbiter-side line request/response signals and the SoC
//   memory bus beat signals of the bridge.
//   Arbiter side : addr_i, cs_i, we_i, wdata_i -> rdata_o, rvalid_o, err_o
//   Bus side     : bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
//                  <- bus_gnt_i, bus_rvalid_i, bus_rdata_i
//   Modports: slave  = the bridge itself
//             master = the environment (arbiter plus memory bus)
interface mem_line_bridge_if
  import mem_line_bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int LINE_W = DATA_WIDTH_CACHE,
  parameter int BUS_W  = BUS_WIDTH
);

  logic [ADDR_W-1:0] addr_i;
  logic              cs_i;
  logic              we_i;
  logic [LINE_W-1:0] wdata_i;
  logic [LINE_W-1:0] rdata_o;
  logic              rvalid_o;
  logic              err_o;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [BUS_W-1:0]  bus_wdata_o;
  logic              bus_gnt_i;
  logic              bus_rvalid_i;
  logic [BUS_W-1:0]  bus_rdata_i;

  modport slave (
    input  addr_i, cs_i, we_i, wdata_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    output rdata_o, rvalid_o, err_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );

  modport master (
    output addr_i, cs_i, we_i, wdata_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    input  rdata_o, rvalid_o, err_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );

endinterface

// File: rtl/mem_line_bridge.sv
// mem_line_bridge
//   Takes one cache-line request at a time from the icache/dcache arbiter,
//   splits it into word beats on the SoC memory bus (one beat outstanding),
//   reassembles read data into a line and returns the line or a write
//   acknowledge as a one-cycle rvalid_o pulse.
// Ports:
//   clk_i  - system clock
//   rst_ni - asynchronous active-low reset
//   lb     - mem_line_bridge_if.slave, arbiter and memory bus signals
// Optional feature:
//   MEM_BRIDGE_TIMEOUT_EN - per-beat watchdog; after TIMEOUT_CYCLES in REQ
//   or RESP the line completes with err_o=1 and rdata_o=0. Without it the
//   bridge waits indefinitely and err_o is tied 0.
module mem_line_bridge
  import mem_line_bridge_pkg::*;
#(
  parameter int ADDR_W         = ADDR_WIDTH,
  parameter int LINE_W         = DATA_WIDTH_CACHE,
  parameter int BUS_W          = BUS_WIDTH,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  mem_line_bridge_if.slave lb
);

  localparam int BEATS      = beatCount(LINE_W, BUS_W);
  localparam int BEAT_IDX_W = beatIdxWidth(BEATS);
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int WORD_SHIFT = $clog2(BUS_W / 8);

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0]     LINE_MASK = ADDR_W'(LINE_BYTES - 1);

  bridgeState_t r_state;
  logic [BEAT_IDX_W-1:0]       r_beat;
  logic [ADDR_W-1:0]           r_baseAddr;
  logic                        r_we;
  logic [BEATS-1:0][BUS_W-1:0] r_wline;
  logic [BEATS-1:0][BUS_W-1:0] r_rline;

  logic              r_busReq;
  logic              r_busWe;
  logic [ADDR_W-1:0] r_busAddr;
  logic [BUS_W-1:0]  r_busWdata;
  logic              r_rvalid;
  logic [LINE_W-1:0] r_rdata;

  logic [BEAT_IDX_W-1:0]       w_beatNext;
  logic [ADDR_W-1:0]           w_nextAddr;
  logic [BEATS-1:0][BUS_W-1:0] w_rlineMerged;

  assign w_beatNext = r_beat + BEAT_IDX_W'(1);
  assign w_nextAddr = r_baseAddr + (ADDR_W'(w_beatNext) << WORD_SHIFT);

  // Line buffer with the current beat's read word dropped in, so the last
  // beat can be returned in the same edge it is captured.
  always_comb begin
    w_rlineMerged         = r_rline;
    w_rlineMerged[r_beat] = lb.bus_rdata_i;
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_err;
  logic [WDOG_W-1:0] w_wdogNext;
  logic              w_expired;

  assign w_wdogNext = r_wdog + WDOG_W'(1);
  assign w_expired  = (w_wdogNext == WDOG_LIMIT);
`endif

  // Single FSM; all bus and completion outputs are registered here so they
  // hold steady while a grant is pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_beat     <= '0;
      r_baseAddr <= '0;
      r_we       <= 1'b0;
      r_wline    <= '0;
      r_rline    <= '0;
      r_busReq   <= 1'b0;
      r_busWe    <= 1'b0;
      r_busAddr  <= '0;
      r_busWdata <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      r_wdog     <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      r_err    <= 1'b0;
      r_wdog   <= '0;
`endif
      case (r_state)
        IDLE: begin
          if (lb.cs_i) begin
            r_baseAddr <= lb.addr_i & ~LINE_MASK;
            r_we       <= lb.we_i;
            r_wline    <= lb.wdata_i;
            r_rline    <= '0;
            r_beat     <= '0;
            r_busReq   <= 1'b1;
            r_busWe    <= lb.we_i;
            r_busAddr  <= lb.addr_i & ~LINE_MASK;
            r_busWdata <= lb.wdata_i[BUS_W-1:0];
            r_state    <= REQ;
          end
        end

        REQ: begin
`ifdef MEM_BRIDGE_TIMEOUT_EN
          r_wdog <= w_wdogNext;
`endif
          if (lb.bus_gnt_i) begin
            r_busReq <= 1'b0;
            r_state  <= RESP;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            r_wdog   <= '0;
          end else if (w_expired) begin
            r_busReq <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= DONE;
`endif
          end
        end

        RESP: begin
`ifdef MEM_BRIDGE_TIMEOUT_EN
          r_wdog <= w_wdogNext;
`endif
          if (lb.bus_rvalid_i) begin
            if (!r_we) begin
              r_rline <= w_rlineMerged;
            end
            if (r_beat == LAST_BEAT) begin
              r_rvalid <= 1'b1;
              r_rdata  <= r_we ? '0 : w_rlineMerged;
              r_state  <= DONE;
            end else begin
              r_beat     <= w_beatNext;
              r_busReq   <= 1'b1;
              r_busAddr  <= w_nextAddr;
              r_busWdata <= r_wline[w_beatNext];
              r_state    <= REQ;
`ifdef MEM_BRIDGE_TIMEOUT_EN
              r_wdog     <= '0;
`endif
            end
`ifdef MEM_BRIDGE_TIMEOUT_EN
          end else if (w_expired) begin
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= DONE;
`endif
          end
        end

        // cs_i is deliberately not looked at here: upstream may still be
        // holding the request that just completed.
        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign lb.bus_req_o   = r_busReq;
  assign lb.bus_we_o    = r_busWe;
  assign lb.bus_addr_o  = r_busAddr;
  assign lb.bus_wdata_o = r_busWdata;
  assign lb.rvalid_o    = r_rvalid;
  assign lb.rdata_o     = r_rdata;
`ifdef MEM_BRIDGE_TIMEOUT_EN
  assign lb.err_o       = r_err;
`else
  assign lb.err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_line_bridge.sv
// tb_mem_line_bridge
//   Directed bench for mem_line_bridge: a memory-bus responder with
//   configurable grant delay and spurious responses, scoreboards of expected
//   bus beats and expected line completions, and a linear stimulus sequence.
//   The watchdog step is built only when MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_mem_line_bridge;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    logic [127:0] rdata;
    logic         err;
  } done_t;

  logic clk = 1'b0;
  logic rstN;

  always #5 clk = ~clk;

  mem_line_bridge_if #(.ADDR_W(32), .LINE_W(128), .BUS_W(32)) lb ();

  mem_line_bridge #(
    .ADDR_W(32),
    .LINE_W(128),
    .BUS_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i (clk),
    .rst_ni(rstN),
    .lb    (lb)
  );

  beat_t       expBeats[$];
  done_t       expDone[$];
  logic [31:0] memData[4];

  int compareCnt  = 0;
  int mismatchCnt = 0;
  int gntDelay    = 0;
  bit memEnable   = 1'b1;
  bit spuriousEn  = 1'b0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compareCnt++;
    assert (obs === exp) else begin
      mismatchCnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one line request and push the beats and completion it should produce.
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [127:0] wline,
                               input bit hold, input int nBeats, input bit expectDone, input logic expErr);
    logic [31:0]  base;
    logic [127:0] sh;
    beat_t        b;
    done_t        d;
    base = addr & ~32'hF;
    for (int i = 0; i < nBeats; i++) begin
      sh      = wline >> (i * 32);
      b.addr  = base + 32'(i * 4);
      b.we    = we;
      b.wdata = sh[31:0];
      expBeats.push_back(b);
    end
    if (expectDone) begin
      d.err   = expErr;
      d.rdata = (we || expErr) ? 128'h0 : {memData[3], memData[2], memData[1], memData[0]};
      expDone.push_back(d);
    end
    lb.cs_i    = 1'b1;
    lb.addr_i  = addr;
    lb.we_i    = we;
    lb.wdata_i = wline;
    @(posedge clk);
    #1;
    if (!hold) begin
      lb.cs_i    = 1'b0;
      lb.addr_i  = $urandom;
      lb.we_i    = ~we;
      lb.wdata_i = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Count cycles after acceptance until rvalid_o; cycle 1 is the first REQ cycle.
  task automatic waitDone(input int maxCyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!lb.rvalid_o && cyc < maxCyc);
    checkOutput("doneSeen", 128'(lb.rvalid_o), 128'(1'b1));
  endtask

  // Memory bus responder: grants after gntDelay waiting cycles, answers the
  // next cycle, and checks every granted beat against the beat scoreboard.
  initial begin
    logic [31:0] pendAddr;
    logic [31:0] holdAddr;
    logic [31:0] holdWdata;
    logic        holdWe;
    beat_t       b;
    bit          rspPending;
    int          waitCnt;
    rspPending      = 1'b0;
    waitCnt         = 0;
    pendAddr        = '0;
    holdAddr        = '0;
    holdWdata       = '0;
    holdWe          = 1'b0;
    lb.bus_gnt_i    = 1'b0;
    lb.bus_rvalid_i = 1'b0;
    lb.bus_rdata_i  = '0;
    forever begin
      @(negedge clk);
      lb.bus_gnt_i    = 1'b0;
      lb.bus_rvalid_i = 1'b0;
      lb.bus_rdata_i  = '0;
      if (!rstN) begin
        rspPending = 1'b0;
        waitCnt    = 0;
      end else if (rspPending) begin
        lb.bus_rvalid_i = 1'b1;
        lb.bus_rdata_i  = memData[pendAddr[3:2]];
        rspPending      = 1'b0;
      end else begin
        if (lb.bus_req_o && memEnable) begin
          if (waitCnt == 0) begin
            holdAddr  = lb.bus_addr_o;
            holdWdata = lb.bus_wdata_o;
            holdWe    = lb.bus_we_o;
          end else begin
            checkOutput("stableAddr", 128'(lb.bus_addr_o), 128'(holdAddr));
            checkOutput("stableWdata", 128'(lb.bus_wdata_o), 128'(holdWdata));
            checkOutput("stableWe", 128'(lb.bus_we_o), 128'(holdWe));
          end
          if (waitCnt >= gntDelay) begin
            lb.bus_gnt_i = 1'b1;
            waitCnt      = 0;
            pendAddr     = lb.bus_addr_o;
            rspPending   = 1'b1;
            if (expBeats.size() == 0) begin
              checkOutput("unexpectedBeat", 128'(lb.bus_req_o), 128'(1'b0));
            end else begin
              b = expBeats.pop_front();
              checkOutput("beatAddr", 128'(lb.bus_addr_o), 128'(b.addr));
              checkOutput("beatWe", 128'(lb.bus_we_o), 128'(b.we));
              if (b.we) begin
                checkOutput("beatWdata", 128'(lb.bus_wdata_o), 128'(b.wdata));
              end
            end
          end else begin
            waitCnt++;
          end
        end
        if (spuriousEn && !lb.bus_gnt_i) begin
          lb.bus_rvalid_i = 1'b1;
          lb.bus_rdata_i  = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
        end
      end
    end
  end

  // Completion monitor: pops the expected line on every rvalid_o and checks
  // that rdata_o/err_o stay 0 in all other cycles.
  always @(negedge clk) begin
    done_t d;
    if (rstN) begin
      if (lb.rvalid_o) begin
        if (expDone.size() == 0) begin
          checkOutput("unexpectedDone", 128'(lb.rvalid_o), 128'(1'b0));
        end else begin
          d = expDone.pop_front();
          checkOutput("rdata", lb.rdata_o, d.rdata);
          checkOutput("err", 128'(lb.err_o), 128'(d.err));
        end
      end else begin
        checkOutput("idleRdata", lb.rdata_o, 128'h0);
        checkOutput("idleErr", 128'(lb.err_o), 128'(1'b0));
      end
    end
  end

  // Global bound so a stuck DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: observed=stuck expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int cyc;
    rstN       = 1'b0;
    lb.cs_i    = 1'b0;
    lb.we_i    = 1'b0;
    lb.addr_i  = '0;
    lb.wdata_i = '0;
    memData    = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstRvalid", 128'(lb.rvalid_o), 128'(1'b0));
    checkOutput("rstRdata", lb.rdata_o, 128'h0);
    checkOutput("rstErr", 128'(lb.err_o), 128'(1'b0));
    checkOutput("rstBusReq", 128'(lb.bus_req_o), 128'(1'b0));
    checkOutput("rstBusWe", 128'(lb.bus_we_o), 128'(1'b0));
    checkOutput("rstBusAddr", 128'(lb.bus_addr_o), 128'h0);
    checkOutput("rstBusWdata", 128'(lb.bus_wdata_o), 128'h0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait line read
    $display("[TB] line read, zero-wait bus");
    applyStimulus(32'h0000_0810, 1'b0, 128'h0, 1'b0, 4, 1'b1, 1'b0);
    waitDone(60, cyc);
    checkOutput("readLatency", 128'(cyc), 128'd9);
    @(negedge clk);
    checkOutput("rvalidPulse", 128'(lb.rvalid_o), 128'(1'b0));

    // Line write with delayed grants
    $display("[TB] line write, grant delayed 3 cycles");
    gntDelay = 3;
    applyStimulus(32'h0000_1000, 1'b1,
                  {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA},
                  1'b0, 4, 1'b1, 1'b0);
    waitDone(100, cyc);
    checkOutput("writeLatency", 128'(cyc), 128'd21);
    gntDelay = 0;
    @(negedge clk);

    // cs_i held through DONE, next request accepted in the following IDLE cycle
    $display("[TB] cs_i held through DONE");
    memData = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404};
    applyStimulus(32'h0000_2000, 1'b0, 128'h0, 1'b1, 4, 1'b1, 1'b0);
    waitDone(60, cyc);
    @(negedge clk);
    checkOutput("holdIdleReq", 128'(lb.bus_req_o), 128'(1'b0));
    applyStimulus(32'h0000_2400, 1'b0, 128'h0, 1'b0, 4, 1'b1, 1'b0);
    waitDone(60, cyc);
    checkOutput("b2bLatency", 128'(cyc), 128'd9);
    @(negedge clk);
    applyStimulus(32'h0000_2800, 1'b0, 128'h0, 1'b1, 4, 1'b1, 1'b0);
    waitDone(60, cyc);
    @(posedge clk);
    #1;
    lb.cs_i = 1'b0;
    @(negedge clk);
    checkOutput("noReaccept1", 128'(lb.bus_req_o), 128'(1'b0));
    @(negedge clk);
    checkOutput("noReaccept2", 128'(lb.bus_req_o), 128'(1'b0));

    // Reset during beat 2 of a read
    $display("[TB] reset during beat 2");
    applyStimulus(32'h0000_3000, 1'b0, 128'h0, 1'b0, 3, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    checkOutput("beat2Req", 128'(lb.bus_req_o), 128'(1'b1));
    checkOutput("beat2Addr", 128'(lb.bus_addr_o), 128'h3008);
    rstN = 1'b0;
    #1;
    checkOutput("rstDropsReq", 128'(lb.bus_req_o), 128'(1'b0));
    checkOutput("rstNoRvalid", 128'(lb.rvalid_o), 128'(1'b0));
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    checkOutput("rstBeatsLeft", 128'(expBeats.size()), 128'd0);
    @(negedge clk);
    memData = '{32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
    applyStimulus(32'h0000_0810, 1'b0, 128'h0, 1'b0, 4, 1'b1, 1'b0);
    waitDone(60, cyc);
    checkOutput("postRstLatency", 128'(cyc), 128'd9);
    @(negedge clk);

    // Spurious bus_rvalid_i in IDLE and REQ, unaligned address
    $display("[TB] spurious bus responses");
    memData    = '{32'h5A5A_0000, 32'h5A5A_1111, 32'h5A5A_2222, 32'h5A5A_3333};
    spuriousEn = 1'b1;
    gntDelay   = 2;
    repeat (3) @(negedge clk);
    applyStimulus(32'h0000_004C, 1'b0, 128'h0, 1'b0, 4, 1'b1, 1'b0);
    waitDone(100, cyc);
    checkOutput("spurLatency", 128'(cyc), 128'd17);
    @(negedge clk);
    spuriousEn = 1'b0;
    gntDelay   = 0;
    @(negedge clk);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    // Grant never arrives: watchdog aborts the line
    $display("[TB] watchdog abort");
    memEnable = 1'b0;
    applyStimulus(32'h0000_0500, 1'b0, 128'h0, 1'b0, 0, 1'b1, 1'b1);
    waitDone(60, cyc);
    checkOutput("abortLatency", 128'(cyc), 128'd9);
    checkOutput("abortReqDropped", 128'(lb.bus_req_o), 128'(1'b0));
    @(negedge clk);
    memEnable = 1'b1;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    checkOutput("beatsLeft", 128'(expBeats.size()), 128'd0);
    checkOutput("donesLeft", 128'(expDone.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
    $finish;
  end

endmodule
